trace_rec_packer: RTL and testbench

//  Synthesizable source of IU commit-trace records. Samples the XC-stage thread state (xcr.ts)

---
 rtl/trace_rec_packer.sv | 212 +++++++++++++++++++++
 tb/tb_trace_rec_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_rec_packer.sv
// ---------------------------------------------------------------------------
// trace_rec_packer
//
// Captures IU commit-trace events from the XC-stage thread state. Each
// qualified event becomes a 4-word record (W0 header, W1 pc, W2 inst,
// W3 cycle stamp) in a circular FIFO. Records leave as a 32-bit
// valid/ready word stream, one record per four handshakes, for the host
// to decode and disassemble.
//
// Ports
//   gclk           IU clock bundle; all state on posedge gclk.clk
//   rst            asynchronous active-low reset
//   xcr            XC-stage register (thread state fields are sampled)
//   dcache_replay  D-cache replay of the XC instruction, OR'd into W0
//   trace_en       capture enable; buffered records drain regardless
//   rec_data       current stream word
//   rec_valid      rec_data valid
//   rec_last       marks W3, the final word of a record
//   rec_ready      downstream accepts the word on rec_valid & rec_ready
//   drop_cnt       saturating count of records lost to a full FIFO
//   fifo_full      FIFO holds DEPTH records
// ---------------------------------------------------------------------------
package trace_rec_pkg;

  localparam int TID_W = 4;
  localparam int UPC_W = 8;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic             run;
    logic             dma_mode;
    logic             icmiss;
    logic [TID_W-1:0] tid;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             replay;
    logic             annul;
    logic             ucmode;
    logic [UPC_W-1:0] upc;
  } thread_state_type;

  typedef struct packed {
    thread_state_type ts;
  } xc_reg_type;

endpackage

module trace_rec_packer
  import trace_rec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
) (
  input  iu_clk_type       gclk,
  input  logic             rst,
  input  xc_reg_type       xcr,
  input  logic             dcache_replay,
  input  logic             trace_en,
  output logic [31:0]      rec_data,
  output logic             rec_valid,
  output logic             rec_last,
  input  logic             rec_ready,
  output logic [CNTW-1:0]  drop_cnt,
  output logic             fifo_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  logic clk;
  assign clk = gclk.clk;

  // Capture side state
  logic [31:0]     cyc_q;
  logic [7:0]      seq_q;
  logic [CNTW-1:0] drop_q;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            full_q;
  logic [127:0]    mem_q [DEPTH];

  // Serializer state; outputs come straight from these registers
  state_e          state_q;
  logic [1:0]      idx_q;
  logic [31:0]     data_q;
  logic            valid_q;
  logic            last_q;

  logic            ev;
  logic            pop;
  logic            push;
  logic            drop;
  logic [31:0]     w0;
  logic [1:0]      idx_n;
  logic [31:0]     head_w0;
  logic [31:0]     head_wn;
  logic [31:0]     next_w0;

  assign ev   = trace_en & (xcr.ts.run | xcr.ts.dma_mode) & ~xcr.ts.icmiss;
  // A record leaves the FIFO when its W3 is accepted.
  assign pop  = valid_q & rec_ready & last_q;
  // A full FIFO still accepts a push when it frees a slot on the same edge.
  assign push = ev & ((count_q != DEPTH_C) | pop);
  assign drop = ev & ~push;

  assign w0 = {4'hA, xcr.ts.replay | dcache_replay, xcr.ts.annul, xcr.ts.dma_mode,
               xcr.ts.ucmode, 8'(xcr.ts.tid), 8'(xcr.ts.upc), seq_q};

  assign idx_n   = idx_q + 2'd1;
  assign head_w0 = mem_q[head_q][31:0];
  assign head_wn = mem_q[head_q][{idx_n, 5'd0} +: 32];
  assign next_w0 = mem_q[head_q + PW'(1)][31:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      // seq advances on dropped events too, so gaps reveal losses to the host.
      if (ev) seq_q <= seq_q + 8'd1;
      if (drop && (drop_q != '1)) drop_q <= drop_q + CNTW'(1);
      if (push) tail_q <= tail_q + PW'(1);
      if (pop) head_q <= head_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
    end
  end

  // NOTE: the record storage has no reset; head/tail/count define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {cyc_q, xcr.ts.inst, xcr.ts.pc, w0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_SEND;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            idx_q   <= 2'd0;
            data_q  <= head_w0;
          end
        end
        S_SEND: begin
          // valid_q is always high here, so rec_ready alone is the handshake.
          if (rec_ready) begin
            if (idx_q == 2'd3) begin
              idx_q  <= 2'd0;
              last_q <= 1'b0;
              // Records already resident behind the head stream back to back;
              // one pushed on this very edge is picked up from IDLE.
              if (count_q > CW'(1)) begin
                data_q <= next_w0;
              end else begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                data_q  <= '0;
              end
            end else begin
              idx_q  <= idx_n;
              data_q <= head_wn;
              last_q <= (idx_q == 2'd2);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rec_data  = data_q;
  assign rec_valid = valid_q;
  assign rec_last  = last_q;
  assign drop_cnt  = drop_q;
  assign fifo_full = full_q;

endmodule

// File: tb/tb_trace_rec_packer.sv
// ---------------------------------------------------------------------------
// tb_trace_rec_packer
//
// Bench for trace_rec_packer: a table of single-event vectors with hand
// computed records, directed overflow / full-pop / mid-record reset
// sequences, and a randomized run scored against a queue-based model of
// the record FIFO and word stream.
// ---------------------------------------------------------------------------
module tb_trace_rec_packer;
  import trace_rec_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNTW  = 16;

  typedef logic [3:0][31:0] rec_t;

  typedef struct {
    logic        en;
    logic        run;
    logic        dma;
    logic        icm;
    logic        rep;
    logic        drep;
    logic        annul;
    logic        ucm;
    logic [3:0]  tid;
    logic [7:0]  upc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cap;
    logic [31:0] w0;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_l;
  iu_clk_type      gclk_s;
  xc_reg_type      xcr;
  logic            dcache_replay;
  logic            trace_en;
  logic [31:0]     rec_data;
  logic            rec_valid;
  logic            rec_last;
  logic            rec_ready;
  logic [CNTW-1:0] drop_cnt;
  logic            fifo_full;

  assign gclk_s = '{clk: clk};

  always #5 clk = ~clk;

  trace_rec_packer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .gclk          (gclk_s),
    .rst           (rst_l),
    .xcr           (xcr),
    .dcache_replay (dcache_replay),
    .trace_en      (trace_en),
    .rec_data      (rec_data),
    .rec_valid     (rec_valid),
    .rec_last      (rec_last),
    .rec_ready     (rec_ready),
    .drop_cnt      (drop_cnt),
    .fifo_full     (fifo_full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: records waiting or in flight, stream position, counters.
  rec_t        m_q[$];
  int          m_widx;
  logic [7:0]  m_seq;
  logic [31:0] m_cyc;
  int          m_drop;
  logic [31:0] got_q[$];
  logic        prev_valid, prev_ready, prev_last;
  logic [31:0] prev_data;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_widx     = 0;
    m_seq      = 8'd0;
    m_cyc      = 32'd0;
    m_drop     = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_last  = 1'b0;
    prev_data  = 32'd0;
  endtask

  task automatic set_idle();
    xcr           = '0;
    dcache_replay = 1'b0;
  endtask

  task automatic set_ev(input logic [3:0] tid, input logic [31:0] pc, input logic [31:0] inst);
    xcr           = '0;
    dcache_replay = 1'b0;
    xcr.ts.run    = 1'b1;
    xcr.ts.tid    = tid;
    xcr.ts.pc     = pc;
    xcr.ts.inst   = inst;
  endtask

  // Called at a negedge with the inputs for the next posedge already driven.
  // Checks the current outputs, advances the model across that posedge and
  // returns at the following negedge.
  task automatic tick();
    logic ev;
    logic pop;
    int   pre_size;
    rec_t r;
    if (prev_valid && !prev_ready) begin
      check("hold_valid", rec_valid, 1);
      check("hold_data", rec_data, prev_data);
      check("hold_last", rec_last, prev_last);
    end
    check("drop_cnt", drop_cnt, m_drop);
    check("fifo_full", fifo_full, (m_q.size() == DEPTH));
    if (m_q.size() == 0) check("valid_when_empty", rec_valid, 0);

    pop = 1'b0;
    if (rec_valid && rec_ready) begin
      got_q.push_back(rec_data);
      if (m_q.size() != 0) begin
        check("word", rec_data, m_q[0][m_widx]);
        check("last", rec_last, (m_widx == 3));
        if (m_widx == 3) begin
          pop    = 1'b1;
          m_widx = 0;
        end else begin
          m_widx++;
        end
      end
    end

    ev = trace_en & (xcr.ts.run | xcr.ts.dma_mode) & ~xcr.ts.icmiss;
    pre_size = m_q.size();
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      r[0] = {4'hA, xcr.ts.replay | dcache_replay, xcr.ts.annul, xcr.ts.dma_mode,
              xcr.ts.ucmode, 4'h0, xcr.ts.tid, xcr.ts.upc, m_seq};
      r[1] = xcr.ts.pc;
      r[2] = xcr.ts.inst;
      r[3] = m_cyc;
      if (pre_size < DEPTH || pop) m_q.push_back(r);
      else if (m_drop < (1 << CNTW) - 1) m_drop++;
      m_seq = m_seq + 8'd1;
    end
    m_cyc = m_cyc + 32'd1;

    prev_valid = rec_valid;
    prev_ready = rec_ready;
    prev_last  = rec_last;
    prev_data  = rec_data;
    @(negedge clk);
  endtask

  // Entered at a negedge; asserts reset between edges and checks that the
  // outputs clear without waiting for a clock.
  task automatic do_reset();
    #2 rst_l = 1'b0;
    #1;
    check("rst_valid", rec_valid, 0);
    check("rst_last", rec_last, 0);
    check("rst_data", rec_data, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_full", fifo_full, 0);
    model_reset();
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic drain(input int budget);
    rec_ready = 1'b1;
    set_idle();
    for (int i = 0; i < budget; i++) begin
      if (m_q.size() == 0 && !rec_valid) break;
      tick();
    end
    check("drain_model_empty", m_q.size(), 0);
    check("drain_valid_low", rec_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 8'h00,
                32'h4000_1000, 32'h9DE3_BFA0, 1'b1, 32'hA003_0000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 8'h00,
                32'h4000_1000, 32'h9DE3_BFA0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'h11,
                32'h4000_2000, 32'h0100_0000, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'h22,
                32'h4000_3000, 32'h0100_0000, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 8'hBC,
                32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 32'hAF0F_BC00};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 8'h12,
                32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hAA05_1200};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 8'h33,
                32'h4000_4000, 32'h0100_0000, 1'b0, 32'h0};

    rst_l     = 1'b0;
    trace_en  = 1'b0;
    rec_ready = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);

    // Single-event vectors: event sampled when the cycle counter reads 5.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      trace_en  = vecs[v].en;
      rec_ready = 1'b1;
      repeat (5) tick();
      got_q.delete();
      xcr              = '0;
      xcr.ts.run       = vecs[v].run;
      xcr.ts.dma_mode  = vecs[v].dma;
      xcr.ts.icmiss    = vecs[v].icm;
      xcr.ts.replay    = vecs[v].rep;
      dcache_replay    = vecs[v].drep;
      xcr.ts.annul     = vecs[v].annul;
      xcr.ts.ucmode    = vecs[v].ucm;
      xcr.ts.tid       = vecs[v].tid;
      xcr.ts.upc       = vecs[v].upc;
      xcr.ts.pc        = vecs[v].pc;
      xcr.ts.inst      = vecs[v].inst;
      tick();
      set_idle();
      tick();
      check("vec_latency_valid", rec_valid, vecs[v].cap);
      if (vecs[v].cap) check("vec_latency_w0", rec_data, vecs[v].w0);
      repeat (7) tick();
      check("vec_nwords", got_q.size(), vecs[v].cap ? 4 : 0);
      if (vecs[v].cap && got_q.size() == 4) begin
        check("vec_w0", got_q[0], vecs[v].w0);
        check("vec_w1", got_q[1], vecs[v].pc);
        check("vec_w2", got_q[2], vecs[v].inst);
        check("vec_w3", got_q[3], 32'd5);
      end
    end

    // Overflow: DEPTH+3 events with the stream stalled.
    do_reset();
    trace_en  = 1'b1;
    rec_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_ev(4'(i), 32'h5000_0000 + 32'(i), 32'h8000_0000 | 32'(i));
      tick();
    end
    set_idle();
    check("ovf_full", fifo_full, 1);
    check("ovf_drop", drop_cnt, 3);
    got_q.delete();
    rec_ready = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < 4 * DEPTH; i++) tick();
    check("ovf_nwords", got_q.size(), 4 * DEPTH);
    if (got_q.size() == 4 * DEPTH) begin
      for (int i = 0; i < DEPTH; i++) check("ovf_seq", {24'd0, got_q[4 * i][7:0]}, i);
    end
    drain(20);
    got_q.delete();
    set_ev(4'h7, 32'h6000_0000, 32'h0100_0000);
    tick();
    drain(20);
    check("ovf_next_seq", (got_q.size() > 0) ? {24'd0, got_q[0][7:0]} : 32'hFFFF_FFFF, 19);

    // Full FIFO: event on the same edge as the W3 handshake is accepted.
    do_reset();
    trace_en  = 1'b1;
    rec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_ev(4'(i), 32'h7000_0000 + 32'(i), 32'h0);
      tick();
    end
    set_idle();
    check("fp_full_before", fifo_full, 1);
    rec_ready = 1'b1;
    repeat (3) tick();
    check("fp_last_pending", rec_last, 1);
    set_ev(4'hE, 32'h7777_7777, 32'h1234_0000);
    tick();
    set_idle();
    check("fp_drop", drop_cnt, 0);
    check("fp_full_after", fifo_full, 1);
    drain(200);

    // Reset in the middle of a record, then a fresh record starts at seq 0.
    do_reset();
    trace_en  = 1'b1;
    rec_ready = 1'b1;
    set_ev(4'h9, 32'h4000_9000, 32'h0300_0000);
    tick();
    set_idle();
    repeat (3) tick();
    check("mid_w2_showing", rec_data, 32'h0300_0000);
    do_reset();
    trace_en = 1'b1;
    got_q.delete();
    set_ev(4'h4, 32'h4000_A000, 32'h0400_0000);
    tick();
    drain(20);
    check("mid_nwords", got_q.size(), 4);
    check("mid_w0", (got_q.size() > 0) ? got_q[0] : 32'hFFFF_FFFF, 32'hA004_0000);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trace_en         = ($urandom_range(0, 9) != 0);
      rec_ready        = $urandom_range(0, 1) == 1;
      xcr.ts.run       = ($urandom_range(0, 9) < 4);
      xcr.ts.dma_mode  = ($urandom_range(0, 9) < 2);
      xcr.ts.icmiss    = ($urandom_range(0, 9) < 2);
      xcr.ts.tid       = 4'($urandom);
      xcr.ts.upc       = 8'($urandom);
      xcr.ts.pc        = $urandom;
      xcr.ts.inst      = $urandom;
      xcr.ts.replay    = 1'($urandom);
      xcr.ts.annul     = 1'($urandom);
      xcr.ts.ucmode    = 1'($urandom);
      dcache_replay    = 1'($urandom);
      tick();
    end
    drain(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
